sbox_share_ctrl: RTL and testbench



---
 rtl/sbox_share_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_sbox_share_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_ctrl.sv
// -----------------------------------------------------------------------------
// sbox_share_ctrl
//
// Iterative SubBytes engine. Four Sbox instances form one 32-bit lane that is
// time-shared between two requesters:
//   - state path : 128-bit SubBytes block, processed as four 32-bit beats
//                  (most significant word first)
//   - key path   : 32-bit SubWord, processed in a single beat
// Each path has a request handshake (valid/ready) and a result handshake
// (out_valid/out_ready). A result is held, with stable data, until consumed.
// A pending result stalls only its own requester.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   blk_valid/ready  state-path request handshake, blk_data is the 128-bit state
//   blk_out_*        substituted block, held until blk_out_ready
//   wrd_valid/ready  key-path request handshake, wrd_data is the 32-bit word
//   wrd_out_*        substituted word, held until wrd_out_ready
//   busy             a transaction is in flight (FSM not idle)
// -----------------------------------------------------------------------------

// Single AES Sbox, computed as the GF(2^8) multiplicative inverse followed by
// the AES affine transform. Purely combinational.
module sbox_share_ctrl_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Multiplication modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] s);
    return s
         ^ {s[6:0], s[7]}
         ^ {s[5:0], s[7:6]}
         ^ {s[4:0], s[7:5]}
         ^ {s[3:0], s[7:4]}
         ^ 8'h63;
  endfunction

  always_comb begin
    dout = affine(gf_inv(din));
  end

endmodule

module sbox_share_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  output logic         blk_out_valid,
  input  logic         blk_out_ready,
  output logic [127:0] blk_out_data,
  input  logic         wrd_valid,
  output logic         wrd_ready,
  input  logic [31:0]  wrd_data,
  output logic         wrd_out_valid,
  input  logic         wrd_out_ready,
  output logic [31:0]  wrd_out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BLK  = 2'd1,
    S_WRD  = 2'd2
  } state_t;

  // Which requester wins when both are eligible in the same IDLE cycle.
  typedef enum logic {
    PRIO_BLK = 1'b0,
    PRIO_WRD = 1'b1
  } prio_t;

  state_t       state, state_nxt;
  logic [1:0]   beat, beat_nxt;
  prio_t        prio, prio_nxt;

  logic [127:0] blk_in;
  logic [31:0]  wrd_in;

  logic         blk_elig, wrd_elig;
  logic         grant_blk, grant_wrd;
  logic         blk_done, wrd_done;

  logic [31:0]  lane_in;
  logic [31:0]  lane_out;

  // ---------------------------------------------------------------------------
  // Shared 32-bit lane: four Sbox instances, byte g in -> byte g out.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 4; g++) begin : g_lane
    sbox_share_ctrl_sbox u_sbox (
      .din  (lane_in[8*g +: 8]),
      .dout (lane_out[8*g +: 8])
    );
  end

  // ---------------------------------------------------------------------------
  // Arbitration. Eligibility looks at the registered out_valid, so a result
  // still waiting for its consumer blocks a new request of the same type
  // while the other requester is free to proceed.
  // ---------------------------------------------------------------------------
  always_comb begin
    blk_elig  = blk_valid & ~blk_out_valid;
    wrd_elig  = wrd_valid & ~wrd_out_valid;
    grant_blk = blk_elig & (~wrd_elig | (prio == PRIO_BLK));
    grant_wrd = wrd_elig & ~grant_blk;
  end

  // ---------------------------------------------------------------------------
  // Next-state, handshake and lane-select logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves a signal unassigned and infers a latch.
    state_nxt = state;
    beat_nxt  = beat;
    prio_nxt  = prio;
    blk_ready = 1'b0;
    wrd_ready = 1'b0;
    lane_in   = 32'h0;
    blk_done  = 1'b0;
    wrd_done  = 1'b0;

    unique case (state)
      S_IDLE: begin
        blk_ready = grant_blk;
        wrd_ready = grant_wrd;
        if (grant_blk) begin
          state_nxt = S_BLK;
          beat_nxt  = 2'd0;
          prio_nxt  = PRIO_WRD;
        end else if (grant_wrd) begin
          state_nxt = S_WRD;
          prio_nxt  = PRIO_BLK;
        end
      end

      S_BLK: begin
        // Beat k works on bits [127-32k -: 32]; ~beat equals 3-beat.
        lane_in  = blk_in[{~beat, 5'd0} +: 32];
        beat_nxt = beat + 2'd1;
        if (beat == 2'd3) begin
          state_nxt = S_IDLE;
          blk_done  = 1'b1;
        end
      end

      S_WRD: begin
        lane_in   = wrd_in;
        state_nxt = S_IDLE;
        wrd_done  = 1'b1;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      beat  <= 2'd0;
      prio  <= PRIO_WRD;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state <= state_nxt;
      beat  <= beat_nxt;
      prio  <= prio_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: request latches and result holding registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide data registers are reset too, so a reset mid-operation
      // leaves no stale plaintext behind and outputs read as zero.
      blk_in        <= 128'h0;
      wrd_in        <= 32'h0;
      blk_out_data  <= 128'h0;
      wrd_out_data  <= 32'h0;
      blk_out_valid <= 1'b0;
      wrd_out_valid <= 1'b0;
    end else begin
      if (blk_ready) blk_in <= blk_data;
      if (wrd_ready) wrd_in <= wrd_data;

      // Results are written in place, one 32-bit slice per beat. The block
      // output is only ever rewritten after its previous value was consumed.
      if (state == S_BLK) blk_out_data[{~beat, 5'd0} +: 32] <= lane_out;
      if (wrd_done)       wrd_out_data <= lane_out;

      // A completion can only occur while out_valid is low, so set and clear
      // never compete.
      if (blk_done) begin
        blk_out_valid <= 1'b1;
      end else if (blk_out_valid && blk_out_ready) begin
        blk_out_valid <= 1'b0;
      end

      if (wrd_done) begin
        wrd_out_valid <= 1'b1;
      end else if (wrd_out_valid && wrd_out_ready) begin
        wrd_out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sbox_share_ctrl
//
// Scoreboard bench for sbox_share_ctrl. Request drivers push the expected
// result (from a table-based SubBytes model) and the accept cycle into a queue
// per path; an independent monitor compares every presented result against
// the head of its queue, checks result latency, and pops on handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sbox_share_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic         blk_out_valid;
  logic         blk_out_ready;
  logic [127:0] blk_out_data;
  logic         wrd_valid;
  logic         wrd_ready;
  logic [31:0]  wrd_data;
  logic         wrd_out_valid;
  logic         wrd_out_ready;
  logic [31:0]  wrd_out_data;
  logic         busy;

  sbox_share_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .blk_valid     (blk_valid),
    .blk_ready     (blk_ready),
    .blk_data      (blk_data),
    .blk_out_valid (blk_out_valid),
    .blk_out_ready (blk_out_ready),
    .blk_out_data  (blk_out_data),
    .wrd_valid     (wrd_valid),
    .wrd_ready     (wrd_ready),
    .wrd_data      (wrd_data),
    .wrd_out_valid (wrd_out_valid),
    .wrd_out_ready (wrd_out_ready),
    .wrd_out_data  (wrd_out_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: the FIPS-197 Sbox table applied byte by byte.
  // ---------------------------------------------------------------------------
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [127:0] sub_block(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[d[8*i +: 8]];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [127:0] data;
    int           acc;   // posedge count of the accept edge
  } exp_t;

  typedef struct {
    logic [7:0] who;     // "B" or "W"
    int         acc;
  } grant_t;

  exp_t   blk_q[$];
  exp_t   wrd_q[$];
  grant_t glog[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rnd_run  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Request drivers. Called just after a falling edge; return just after the
  // falling edge that follows the accept edge.
  // ---------------------------------------------------------------------------
  task automatic send_blk(input logic [127:0] d, input logic [127:0] e);
    exp_t   x;
    grant_t g;
    blk_data  = d;
    blk_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      #1;
      if (blk_ready) begin
        x.data = e;
        x.acc  = cyc + 1;
        blk_q.push_back(x);
        g.who = 8'h42;
        g.acc = cyc + 1;
        glog.push_back(g);
        @(negedge clk);
        blk_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("blk_accept_timeout", 128'd0, 128'd1);
    blk_valid = 1'b0;
  endtask

  task automatic send_wrd(input logic [31:0] d, input logic [31:0] e);
    exp_t   x;
    grant_t g;
    wrd_data  = d;
    wrd_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      #1;
      if (wrd_ready) begin
        x.data = {96'h0, e};
        x.acc  = cyc + 1;
        wrd_q.push_back(x);
        g.who = 8'h57;
        g.acc = cyc + 1;
        glog.push_back(g);
        @(negedge clk);
        wrd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("wrd_accept_timeout", 128'd0, 128'd1);
    wrd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 1000; t++) begin
      if (blk_q.size() == 0 && wrd_q.size() == 0 && !busy) return;
      @(negedge clk);
    end
    check("drain_timeout", 128'd0, 128'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares presented results against the scoreboard.
  // ---------------------------------------------------------------------------
  initial begin
    bit bp;
    bit wp;
    bp = 1'b0;
    wp = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        bp = 1'b0;
        wp = 1'b0;
      end else begin
        if (blk_out_valid) begin
          if (blk_q.size() == 0) begin
            check("blk_out_unexpected", 128'd1, 128'd0);
          end else begin
            check("blk_out_data", blk_out_data, blk_q[0].data);
            if (!bp) check("blk_latency", 128'(cyc - blk_q[0].acc), 128'd4);
            if (blk_out_ready) void'(blk_q.pop_front());
          end
        end
        bp = blk_out_valid;

        if (wrd_out_valid) begin
          if (wrd_q.size() == 0) begin
            check("wrd_out_unexpected", 128'd1, 128'd0);
          end else begin
            check("wrd_out_data", 128'(wrd_out_data), wrd_q[0].data);
            if (!wp) check("wrd_latency", 128'(cyc - wrd_q[0].acc), 128'd1);
            if (wrd_out_ready) void'(wrd_q.pop_front());
          end
        end
        wp = wrd_out_valid;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_ready"},     128'(blk_ready),     128'd0);
    check({tag, "_wrd_ready"},     128'(wrd_ready),     128'd0);
    check({tag, "_blk_out_valid"}, 128'(blk_out_valid), 128'd0);
    check({tag, "_wrd_out_valid"}, 128'(wrd_out_valid), 128'd0);
    check({tag, "_busy"},          128'(busy),          128'd0);
    check({tag, "_blk_out_data"},  blk_out_data,        128'd0);
    check({tag, "_wrd_out_data"},  128'(wrd_out_data),  128'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [127:0] bd;
    logic [31:0]  wd;
    bit           bp_done;

    blk_valid     = 1'b0;
    blk_data      = '0;
    wrd_valid     = 1'b0;
    wrd_data      = '0;
    blk_out_ready = 1'b1;
    wrd_out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention straight out of reset: word first, block on the next IDLE.
    fork
      send_blk(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230);
      send_wrd(32'hcf4f3c09, 32'h8a84eb01);
    join
    check("contention_grants", 128'(glog.size()), 128'd2);
    if (glog.size() == 2) begin
      check("contention_first_is_wrd",  128'(glog[0].who), 128'h57);
      check("contention_second_is_blk", 128'(glog[1].who), 128'h42);
      check("contention_gap",           128'(glog[1].acc - glog[0].acc), 128'd2);
    end
    wait_drain();

    // Repeated simultaneous request with edge values: word wins again.
    glog.delete();
    fork
      send_blk(128'h0, {16{8'h63}});
      send_wrd(32'hff000153, 32'h16637ced);
    join
    if (glog.size() > 0) check("third_grant_is_wrd", 128'(glog[0].who), 128'h57);
    else check("third_grant_present", 128'd0, 128'd1);
    wait_drain();

    // Byte-wise word substitution of the unrotated key word.
    send_wrd(32'h09cf4f3c, sub_word(32'h09cf4f3c));
    wait_drain();

    // Backpressure on the block result.
    blk_out_ready = 1'b0;
    bd = {$urandom, $urandom, $urandom, $urandom};
    send_blk(bd, sub_block(bd));
    for (int t = 0; t < 20 && !blk_out_valid; t++) @(negedge clk);
    check("bp_first_block_done", 128'(blk_out_valid), 128'd1);
    bp_done = 1'b0;
    bd = {$urandom, $urandom, $urandom, $urandom};
    fork
      begin
        send_blk(bd, sub_block(bd));
        bp_done = 1'b1;
      end
    join_none
    wd = $urandom;
    send_wrd(wd, sub_word(wd));
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      #1;
      check("bp_blk_ready_low", 128'(blk_ready), 128'd0);
    end
    check("bp_word_completed", 128'(wrd_q.size()), 128'd0);
    @(negedge clk);
    blk_out_ready = 1'b1;
    for (int t = 0; t < 50 && !bp_done; t++) @(negedge clk);
    check("bp_second_block_accepted", 128'(bp_done), 128'd1);
    wait_drain();

    // Randomised traffic on both paths with random result backpressure.
    rnd_run = 1'b1;
    fork
      begin
        forever begin
          @(negedge clk);
          if (!rnd_run) break;
          blk_out_ready = 1'($urandom_range(0, 1));
          wrd_out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [127:0] r;
          r = {$urandom, $urandom, $urandom, $urandom};
          send_blk(r, sub_block(r));
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 80; i++) begin
          logic [31:0] r;
          r = $urandom;
          send_wrd(r, sub_word(r));
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join
    rnd_run       = 1'b0;
    blk_out_ready = 1'b1;
    wrd_out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a block (beat 2).
    bd = {$urandom, $urandom, $urandom, $urandom};
    send_blk(bd, sub_block(bd));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midblk_reset");
    blk_q.delete();
    wrd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      #1;
      check("post_reset_no_blk_out", 128'(blk_out_valid), 128'd0);
    end
    check("post_reset_idle", 128'(busy), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
